// File: rtl/raptor64_wb_mem.sv
// raptor64_wb_mem
// ---------------------------------------------------------------------------
// Wishbone B3 responder that serves Raptor64 instruction and data cycles
// from on-chip block RAM. It decodes an aligned address window and supports
// classic cycles as well as incrementing bursts (linear, wrap4, wrap8, wrap16).
// Wait states are configurable, writes honour the byte lanes, and ack/data are
// registered.
//
// Parameters
//   AWID        : log2 of the memory depth in 64-bit words (window = 2^(AWID+3) bytes)
//   BASE        : window base byte address, aligned to the window size
//   WAIT_STATES : extra clocks before the first ack of each cycle (0..15)
//
// Ports
//   clk_i   in   1  clock
//   rst_i   in   1  asynchronous active-high reset
//   cyc_i   in   1  bus cycle valid
//   stb_i   in   1  strobe
//   we_i    in   1  write enable
//   sel_i   in   8  byte lane selects
//   adr_i   in  64  byte address (bits [2:0] ignored)
//   cti_i   in   3  cycle type (000 classic, 010 incrementing, 111 end of burst)
//   bte_i   in   2  burst type (00 linear, 01 wrap4, 10 wrap8, 11 wrap16)
//   dat_i   in  64  write data
//   dat_o   out 64  read data (registered)
//   ack_o   out  1  transfer acknowledge (registered)
//   err_o   out  1  error acknowledge (only with RAPTOR64_WBMEM_ERR_EN)
//
// Optional feature macro: RAPTOR64_WBMEM_ERR_EN. When it is defined, an
// access outside the window gets a one-cycle err_o. When it is undefined,
// err_o is absent and such accesses are ignored.
// ---------------------------------------------------------------------------
module raptor64_wb_mem #(
    parameter int          AWID        = 12,
    parameter logic [63:0] BASE        = 64'h0,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [7:0]  sel_i,
    input  logic [63:0] adr_i,
    input  logic [2:0]  cti_i,
    input  logic [1:0]  bte_i,
    input  logic [63:0] dat_i,
    output logic [63:0] dat_o,
    output logic        ack_o
`ifdef RAPTOR64_WBMEM_ERR_EN
    ,
    output logic        err_o
`endif
);

    localparam int DEPTH = 1 << AWID;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [AWID-1:0]   r_idx;
    logic [AWID-1:0]   w_next_idx;
    logic [3:0]        r_wcnt;
    logic [3:0]        w_next_wcnt;
    logic              r_ack;
    logic              w_next_ack;
    logic              w_mem_we;
    logic [63:0]       r_dat;
    logic [63:0]       r_ram_q;
    logic [63:0]       r_mem [DEPTH];
    logic              w_hit;
    logic              w_req;
    logic              w_unused;
`ifdef RAPTOR64_WBMEM_ERR_EN
    logic              r_err;
    logic              w_next_err;
`endif

    assign w_hit    = (adr_i[63:AWID+3] == BASE[63:AWID+3]);
    assign w_req    = cyc_i & stb_i;
    assign w_unused = &{1'b0, adr_i[2:0]};

    // Next burst index: only the bits covered by the wrap size take the
    // increment; linear bursts wrap naturally at the memory depth.
    function automatic logic [AWID-1:0] f_burst_next(input logic [AWID-1:0] idx,
                                                     input logic [1:0]      bte);
        logic [AWID-1:0] v_mask;
        logic [AWID-1:0] v_inc;
        v_inc = idx + AWID'(4'd1);
        case (bte)
            2'b01:   v_mask = AWID'(4'h3);
            2'b10:   v_mask = AWID'(4'h7);
            2'b11:   v_mask = AWID'(4'hF);
            default: v_mask = {AWID{1'b1}};
        endcase
        return (idx & ~v_mask) | (v_inc & v_mask);
    endfunction

    // Next-state, index, wait counter and beat decode.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_wcnt  = r_wcnt;
        w_next_ack   = 1'b0;
        w_mem_we     = 1'b0;
`ifdef RAPTOR64_WBMEM_ERR_EN
        w_next_err   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_req && w_hit) begin
                    w_next_idx  = adr_i[AWID+2:3];
                    w_next_wcnt = 4'(WAIT_STATES);
                    if (WAIT_STATES > 0) begin
                        w_next_state = S_WAIT;
                    end else begin
                        w_next_state = S_XFER;
                    end
                end
`ifdef RAPTOR64_WBMEM_ERR_EN
                // The !r_err term makes the error pulse exactly one cycle
                // even if the master is slow to drop its strobe.
                else if (w_req && !r_err) begin
                    w_next_err = 1'b1;
                end
`endif
                else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT: begin
                w_next_wcnt = r_wcnt - 4'd1;
                if (!cyc_i) begin
                    w_next_state = S_IDLE;
                end else if (r_wcnt <= 4'd1) begin
                    w_next_state = S_XFER;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_XFER: begin
                if (!cyc_i) begin
                    w_next_state = S_IDLE;
                end else if (stb_i) begin
                    w_next_ack = 1'b1;
                    w_mem_we   = we_i;
                    if (cti_i == 3'b010) begin
                        w_next_idx = f_burst_next(r_idx, bte_i);
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    // Stalled beat: hold index and state, no ack.
                    w_next_state = S_XFER;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_wcnt  <= 4'd0;
            r_ack   <= 1'b0;
            r_dat   <= 64'h0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_wcnt  <= w_next_wcnt;
            r_ack   <= w_next_ack;
            if (w_next_ack && !we_i) begin
                r_dat <= r_ram_q;
            end
        end
    end

`ifdef RAPTOR64_WBMEM_ERR_EN
    // Error acknowledge register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_next_err;
        end
    end

    assign err_o = r_err;
`endif

    // Block RAM read port, addressed with the next index so the word for
    // the coming beat is already in r_ram_q when that beat is acknowledged.
    // No reset here so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        r_ram_q <= r_mem[w_next_idx];
    end

    // Block RAM write port with per-byte lane enables; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (sel_i[i]) begin
                    r_mem[r_idx][8*i +: 8] <= dat_i[8*i +: 8];
                end
            end
        end
    end

    assign dat_o = r_dat;
    assign ack_o = r_ack;

endmodule

// File: tb/tb_raptor64_wb_mem.sv
module tb_raptor64_wb_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc0, stb0, cyc3, stb3, we;
    logic [7:0]  sel;
    logic [63:0] adr, wdat;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [63:0] dat0, dat3;
    logic        ack0, ack3;
`ifdef RAPTOR64_WBMEM_ERR_EN
    logic        err0, err3;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    raptor64_wb_mem #(.AWID(12), .BASE(64'h0), .WAIT_STATES(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc0), .stb_i(stb0), .we_i(we),
        .sel_i(sel), .adr_i(adr), .cti_i(cti), .bte_i(bte), .dat_i(wdat),
        .dat_o(dat0), .ack_o(ack0)
`ifdef RAPTOR64_WBMEM_ERR_EN
        , .err_o(err0)
`endif
    );

    raptor64_wb_mem #(.AWID(12), .BASE(64'h0000_0000_8000_0000), .WAIT_STATES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc3), .stb_i(stb3), .we_i(we),
        .sel_i(sel), .adr_i(adr), .cti_i(cti), .bte_i(bte), .dat_i(wdat),
        .dat_o(dat3), .ack_o(ack3)
`ifdef RAPTOR64_WBMEM_ERR_EN
        , .err_o(err3)
`endif
    );

    typedef struct {
        logic        we;
        logic [7:0]  sel;
        logic [63:0] adr;
        logic [63:0] wd;
        logic [63:0] exp;
        string       nm;
    } vec_t;

    vec_t vt[13];

    function automatic logic [63:0] pat(input int w);
        return 64'hC0DE_0000_0000_0000 | (64'(w) << 32) | 64'(w);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Classic single transfer; ws is the expected wait states of the target.
    task automatic classic(input bit d3, input logic w, input logic [7:0] s,
                           input logic [63:0] a, input logic [63:0] d,
                           input logic [63:0] e, input int ws, input string nm);
        int lat;
        bit got;
        we = w; sel = s; adr = a; wdat = d; cti = 3'b000; bte = 2'b00;
        if (!w) exp_q.push_back(e);
        if (d3) begin cyc3 = 1'b1; stb3 = 1'b1; end
        else    begin cyc0 = 1'b1; stb0 = 1'b1; end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            tick();
            lat++;
            got = d3 ? ack3 : ack0;
        end
        // The first edge samples the request; the ack follows ws+1 clocks later.
        chk({nm, "_lat"}, 64'(lat - 1), 64'(ws + 1));
        if (!w) begin
            if (got) chk({nm, "_dat"}, d3 ? dat3 : dat0, exp_q.pop_front());
            else     void'(exp_q.pop_front());
        end
        cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0; we = 1'b0;
    endtask

    // Four-beat read burst on the zero-wait-state instance.
    task automatic burst4(input logic [63:0] a, input logic [1:0] b,
                          input int wl[4], input string nm);
        int c, beats, first, last;
        for (int k = 0; k < 4; k++) exp_q.push_back(pat(wl[k]));
        we = 1'b0; sel = 8'hFF; adr = a; cti = 3'b010; bte = b;
        cyc0 = 1'b1; stb0 = 1'b1;
        c = 0; beats = 0; first = -1; last = -1;
        while (beats < 4 && c < 40) begin
            tick();
            c++;
            if (ack0) begin
                chk($sformatf("%s_beat%0d", nm, beats), dat0, exp_q.pop_front());
                if (beats == 0) first = c;
                last = c;
                beats++;
                adr = 64'hDEAD_0000_0000_0000;
                if (beats == 3) cti = 3'b111;
            end
        end
        chk({nm, "_beats"}, 64'(beats), 64'd4);
        chk({nm, "_first"}, 64'(first), 64'd2);
        chk({nm, "_nobubble"}, 64'(last - first), 64'd3);
        while (exp_q.size() > 0) void'(exp_q.pop_front());
        cyc0 = 1'b0; stb0 = 1'b0; cti = 3'b000;
        tick();
        chk({nm, "_idle"}, 64'(ack0), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        rst = 1'b1;
        cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0; we = 1'b0;
        sel = 8'h00; adr = 64'h0; wdat = 64'h0; cti = 3'b000; bte = 2'b00;

        vt[0]  = '{1'b1, 8'hFF, 64'h0,    64'h0123_4567_89AB_CDEF, 64'h0, "w_word0"};
        vt[1]  = '{1'b0, 8'hFF, 64'h0,    64'h0, 64'h0123_4567_89AB_CDEF, "r_word0"};
        vt[2]  = '{1'b1, 8'hFF, 64'h8,    64'h0, 64'h0, "w_word1_clr"};
        vt[3]  = '{1'b1, 8'h0F, 64'h8,    64'hFFFF_FFFF_AAAA_AAAA, 64'h0, "w_word1_lo"};
        vt[4]  = '{1'b0, 8'hFF, 64'h8,    64'h0, 64'h0000_0000_AAAA_AAAA, "r_word1_lo"};
        vt[5]  = '{1'b1, 8'hF0, 64'h8,    64'h1234_5678_5555_5555, 64'h0, "w_word1_hi"};
        vt[6]  = '{1'b0, 8'hFF, 64'h8,    64'h0, 64'h1234_5678_AAAA_AAAA, "r_word1_hi"};
        vt[7]  = '{1'b1, 8'hFF, 64'h7FF8, 64'h1111_1111_1111_1111, 64'h0, "w_last"};
        vt[8]  = '{1'b1, 8'h81, 64'h7FF8, 64'hAA00_0000_0000_00BB, 64'h0, "w_last_edge"};
        vt[9]  = '{1'b0, 8'hFF, 64'h7FF8, 64'h0, 64'hAA11_1111_1111_11BB, "r_last"};
        vt[10] = '{1'b0, 8'hFF, 64'h7,    64'h0, 64'h0123_4567_89AB_CDEF, "r_lowbits"};
        vt[11] = '{1'b1, 8'h3C, 64'h7,    64'h0, 64'h0, "w_mid_lanes"};
        vt[12] = '{1'b0, 8'hFF, 64'h0,    64'h0, 64'h0123_0000_0000_CDEF, "r_mid_lanes"};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack_held", 64'(ack0), 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_ack0", 64'(ack0), 64'd0);
        chk("rst_dat0", dat0, 64'h0);
        chk("rst_ack3", 64'(ack3), 64'd0);
        chk("rst_dat3", dat3, 64'h0);

        // Table-driven classic transfers, back to back
        for (int i = 0; i < 13; i++) begin
            classic(1'b0, vt[i].we, vt[i].sel, vt[i].adr, vt[i].wd, vt[i].exp, 0, vt[i].nm);
        end
        tick();
        chk("ack_one_cycle", 64'(ack0), 64'd0);

        // Preload burst patterns
        for (int w = 0; w < 8; w++) classic(1'b0, 1'b1, 8'hFF, 64'(w * 8), pat(w), 64'h0, 0, "preload");
        classic(1'b0, 1'b1, 8'hFF, 64'h7FF0, pat(4094), 64'h0, 0, "preload_hi0");
        classic(1'b0, 1'b1, 8'hFF, 64'h7FF8, pat(4095), 64'h0, 0, "preload_hi1");

        burst4(64'h10,   2'b00, '{2, 3, 4, 5},       "lin");
        burst4(64'h18,   2'b01, '{3, 0, 1, 2},       "wrap4");
        burst4(64'h30,   2'b10, '{6, 7, 0, 1},       "wrap8");
        burst4(64'h7FF0, 2'b00, '{4094, 4095, 0, 1}, "lin_top");

        // Stalled burst, then abort with cyc_i low
        exp_q.push_back(pat(0));
        exp_q.push_back(pat(1));
        we = 1'b0; adr = 64'h0; cti = 3'b010; bte = 2'b00; cyc0 = 1'b1; stb0 = 1'b1;
        tick();
        chk("stall_sample", 64'(ack0), 64'd0);
        tick();
        chk("stall_ack1", 64'(ack0), 64'd1);
        chk("stall_dat1", dat0, exp_q.pop_front());
        stb0 = 1'b0;
        repeat (2) begin
            tick();
            chk("stall_noack", 64'(ack0), 64'd0);
        end
        stb0 = 1'b1;
        tick();
        chk("stall_ack2", 64'(ack0), 64'd1);
        chk("stall_dat2", dat0, exp_q.pop_front());
        cyc0 = 1'b0;
        tick();
        chk("abort_noack", 64'(ack0), 64'd0);
        stb0 = 1'b0; cti = 3'b000;
        classic(1'b0, 1'b0, 8'hFF, 64'h8, 64'h0, pat(1), 0, "after_abort");

        // Write aborted by cyc_i low must leave memory untouched
        we = 1'b1; sel = 8'hFF; adr = 64'h28; wdat = 64'hFFFF_FFFF_FFFF_FFFF;
        cyc0 = 1'b1; stb0 = 1'b1;
        tick();
        cyc0 = 1'b0;
        tick();
        chk("wabort_noack", 64'(ack0), 64'd0);
        stb0 = 1'b0; we = 1'b0;
        classic(1'b0, 1'b0, 8'hFF, 64'h28, 64'h0, pat(5), 0, "wabort_mem");

        // Wait-state instance at a non-zero base
        classic(1'b1, 1'b1, 8'hFF, 64'h8000_0010, 64'h5A5A_1234_A5A5_4321, 64'h0, 3, "ws3_w");
        classic(1'b1, 1'b0, 8'hFF, 64'h8000_0010, 64'h0, 64'h5A5A_1234_A5A5_4321, 3, "ws3_r");

        // Outside the window
        we = 1'b0; adr = 64'h1_0000_0000; cyc0 = 1'b1; stb0 = 1'b1;
`ifdef RAPTOR64_WBMEM_ERR_EN
        tick();
        chk("miss_err", 64'(err0), 64'd1);
        chk("miss_ack", 64'(ack0), 64'd0);
        cyc0 = 1'b0; stb0 = 1'b0;
        tick();
        chk("miss_err_pulse", 64'(err0), 64'd0);
`else
        acks = 0;
        repeat (8) begin
            tick();
            acks += int'(ack0);
        end
        chk("miss_noack", 64'(acks), 64'd0);
        cyc0 = 1'b0; stb0 = 1'b0;
`endif

        // Reset mid-burst drops ack asynchronously; memory survives
        we = 1'b0; adr = 64'h10; cti = 3'b010; bte = 2'b00; cyc0 = 1'b1; stb0 = 1'b1;
        acks = 0;
        while (!ack0 && acks < 20) begin
            tick();
            acks++;
        end
        chk("rstmid_ack", 64'(ack0), 64'd1);
        chk("rstmid_dat", dat0, pat(2));
        #2 rst = 1'b1;
        #1;
        chk("rstmid_async_ack", 64'(ack0), 64'd0);
        chk("rstmid_async_dat", dat0, 64'h0);
        cyc0 = 1'b0; stb0 = 1'b0; cti = 3'b000;
        tick();
        rst = 1'b0;
        classic(1'b0, 1'b0, 8'hFF, 64'h10, 64'h0, pat(2), 0, "mem_kept");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/raptor64_wb_mem.md
# raptor64_wb_mem

Synchronous 64-bit Wishbone B3 responder that serves Raptor64 instruction and data bus cycles from on-chip block RAM.

- Decodes a base-aligned address window and supports classic cycles plus incrementing and wrapping bursts.
- Inserts a configurable number of wait states and applies byte-lane writes.
- Replaces combinational bench-side memories, so the CPU can run from a boot image with realistic registered-ack timing.

## Interface
Parameters:
- AWID, 12: log2 of memory depth in 64-bit words; window size is 2^(AWID+3) bytes.
- BASE, 64'h0: window base byte address; must be aligned to the window size.
- WAIT_STATES, 0: extra cycles inserted before the first ack of each cycle; range 0-15.

Ports:
- clk_i, in, 1: single clock.
- rst_i, in, 1: reset, asynchronous, active-high.
- cyc_i, in, 1: bus cycle valid.
- stb_i, in, 1: strobe.
- we_i, in, 1: write enable.
- sel_i, in, 8: byte lane selects; bit n selects dat[8n+7:8n].
- adr_i, in, 64: byte address; bits [2:0] are ignored.
- cti_i, in, 3: cycle type. 000 = classic, 010 = incrementing burst, 111 = end of burst.
- bte_i, in, 2: burst type. 00 = linear, 01 = wrap4, 10 = wrap8, 11 = wrap16.
- dat_i, in, 64: write data.
- dat_o, out, 64: read data, registered.
- ack_o, out, 1: transfer acknowledge, registered.
- err_o, out, 1: error acknowledge; present only with RAPTOR64_WBMEM_ERR_EN.

## Operation
Address decode and indexing:
- hit = (adr_i[63:AWID+3] == BASE[63:AWID+3]).
- Word index = adr_i[AWID+2:3].

State machine states: IDLE, WAIT, XFER.
- IDLE:
  - On cyc_i & stb_i & hit: latch the word index into idx, load wcnt = WAIT_STATES.
  - Go to WAIT if WAIT_STATES > 0, else go to XFER.
- WAIT:
  - Decrement wcnt each cycle.
  - Go to XFER when wcnt reaches 1.
- XFER, beat rule: ack_o = 1 on every cycle where stb_i = 1.
- XFER, read beat: dat_o = mem[idx] during that cycle.
- XFER, write beat: lanes with sel_i set are written with dat_i at the clock edge ending the beat; other lanes are unchanged. dat_o is don't-care.
- XFER exit, classic cycle: if cti_i = 000 or 111 on the beat, return to IDLE.
- XFER stay, burst beat: if cti_i = 010 on the beat, idx advances and the state stays XFER.
- Burst index advance:
  - Linear: idx + 1, modulo memory depth.
  - wrap4: increment only idx[1:0].
  - wrap8: increment only idx[2:0].
  - wrap16: increment only idx[3:0].
- Read prefetch: the block RAM is read with the next index so the following beat's data is valid with zero bubbles.
- stb_i low in XFER: ack_o = 0 and idx holds. The burst resumes when stb_i returns, with no new wait states.
- cyc_i low in any state: abort to IDLE next edge, ack_o = 0, no write occurs.
- adr_i is ignored after the first beat of a burst; the internal idx is authoritative.
- Non-decoded address: no response (the master times out), unless the Configuration section applies.
- Memory contents are not cleared by reset.

## Timing
- Reset values: state IDLE, ack_o 0, dat_o 64'h0, err_o 0, idx 0, wcnt 0. Reset asserted mid-burst drops ack_o asynchronously.
- First-ack latency: WAIT_STATES + 1 clocks after the edge that samples cyc_i & stb_i & hit high.
- Burst throughput: subsequent beats take 1 clock each.
- Classic back-to-back: the transfer following an ack is sampled in IDLE on the next edge. Minimum cycle spacing is WAIT_STATES + 2 clocks.
- Read data: dat_o is valid in exactly the cycle ack_o = 1.
- Write ordering: a write at idx followed immediately by a read of idx returns the new data.

## Configuration
- RAPTOR64_WBMEM_ERR_EN defined:
  - err_o exists.
  - In IDLE, cyc_i & stb_i & !hit drives err_o = 1 for exactly one cycle, then returns to IDLE. No wait states apply, and ack_o stays 0.
- RAPTOR64_WBMEM_ERR_EN undefined:
  - Port err_o is omitted.
  - Non-decoded cycles are silently ignored.

## Test plan
- Classic read, WAIT_STATES=0, word 0 preloaded 64'h0123456789ABCDEF, adr_i=0x0 -> ack_o high 1 clock later for one cycle, dat_o=64'h0123456789ABCDEF.
- Byte-lane write, sel_i=8'h0F, dat_i=64'hFFFFFFFF_AAAAAAAA to word 0x8 (initially 0), then read -> 64'h00000000_AAAAAAAA.
- WAIT_STATES=3 classic read -> ack_o on the 4th clock after the strobe is sampled.
- Incrementing linear burst of 4 reads from 0x10 (cti 010,010,010,111) -> 4 consecutive acks returning words 2,3,4,5.
- wrap4 burst of 4 beats starting at 0x18 -> words 3,0,1,2.
- Mid-burst case: stb_i dropped 2 cycles mid-burst, then cyc_i dropped -> no ack while stb_i is low, IDLE next edge. With ERR_EN, access to 0x1_0000_0000 -> single err_o pulse and no ack.
